con_eval_unit: RTL and testbench

- Parametrised successor to the single-bit CON flip-flop; evaluates branch conditions for the conditional-branch datapath.
- Samples bus data and the IR condition field on a load strobe, then decodes in a second stage.
- Registers the taken/not-taken result with a valid pulse.
- Supports an extended 8-code condition set, a legacy 4-code mode, pipeline flush, and optional outcome statistics.

---
 rtl/con_eval_unit_pkg.sv | 42 ++++
 rtl/con_eval_unit_sat_counter.sv | 38 +++
 rtl/gp_register.sv | 28 ++
 rtl/con_eval_unit.sv | 112 +++++++++++
 tb/tb_con_eval_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/con_eval_unit_pkg.sv
// con_pkg: condition-code type, named codes and the branch-condition decode shared by con_eval_unit.
`default_nettype none

package con_pkg;

  typedef logic [2:0] cond_code_t;

  localparam cond_code_t COND_EQZ = 3'b000;
  localparam cond_code_t COND_NEZ = 3'b001;
  localparam cond_code_t COND_GEZ = 3'b010;
  localparam cond_code_t COND_LTZ = 3'b011;
  localparam cond_code_t COND_GTZ = 3'b100;
  localparam cond_code_t COND_LEZ = 3'b101;
  localparam cond_code_t COND_ALW = 3'b110;
  localparam cond_code_t COND_NEV = 3'b111;

  typedef struct packed {
    cond_code_t code;
    logic       is_zero;
    logic       is_neg;
  } s1_t;

  function automatic logic cond_decode(input cond_code_t code, input logic is_zero,
                                       input logic is_neg);
    logic r;
    r = 1'b0;
    case (code)
      COND_EQZ: r = is_zero;
      COND_NEZ: r = ~is_zero;
      COND_GEZ: r = ~is_neg;
      COND_LTZ: r = is_neg;
      COND_GTZ: r = ~is_neg & ~is_zero;
      COND_LEZ: r = is_neg | is_zero;
      COND_ALW: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/con_eval_unit_sat_counter.sv
// con_sat_counter: saturating up-counter with synchronous clear; clear beats increment.
`default_nettype none

module con_sat_counter #(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [STAT_WIDTH-1:0] cnt_o
);

  logic [STAT_WIDTH-1:0] cnt_q;
  logic [STAT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {STAT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/gp_register.sv
// gp_register: general-purpose load-enabled register, synchronous active-low clear to zero.
`default_nettype none

module gp_register #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/con_eval_unit.sv
// con_eval_unit: two-stage branch-condition evaluator (capture, then decode) with flush.
// Optional outcome statistics are built when CON_STATS_EN is defined.
`default_nettype none

module con_eval_unit
  import con_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IR_WIDTH   = 32,
  parameter int COND_LSB   = 19,
  parameter int EXT_COND   = 1,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  con_in_i,
  input  logic                  flush_i,
  input  logic [IR_WIDTH-1:0]   ir_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  con_out_o,
  output logic                  con_valid_o
`ifdef CON_STATS_EN
  ,
  input  logic                  stat_clr_i,
  output logic [STAT_WIDTH-1:0] stat_taken_o,
  output logic [STAT_WIDTH-1:0] stat_not_taken_o
`endif
);

  if ((COND_LSB + 3 > IR_WIDTH) || (DATA_WIDTH < 2)) begin : g_param_check
    $error("con_eval_unit: condition field outside ir or DATA_WIDTH < 2");
  end

  logic       s1_load;
  cond_code_t code_d;
  s1_t        s1_d;
  s1_t        s1_q;
  logic       s1_valid_q;
  logic       con_out_d;
  logic       ir_unused;

  // A flush in the same cycle drops the strobe before it reaches stage 1.
  assign s1_load = con_in_i & ~flush_i;

  if (EXT_COND != 0) begin : g_ext_cond
    assign code_d = ir_i[COND_LSB+2 -: 3];
  end else begin : g_legacy_cond
    assign code_d = {1'b0, ir_i[COND_LSB+1 -: 2]};
  end

  assign ir_unused = ^ir_i;

  assign s1_d.code    = code_d;
  assign s1_d.is_zero = ~|bus_data_i;
  assign s1_d.is_neg  = bus_data_i[DATA_WIDTH-1];

  gp_register #(.WIDTH($bits(s1_t))) u_s1_data (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (s1_load),
    .d_i       (s1_d),
    .q_o       (s1_q)
  );

  gp_register #(.WIDTH(1)) u_s1_valid (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (1'b1),
    .d_i       (s1_load),
    .q_o       (s1_valid_q)
  );

  assign con_out_d = cond_decode(s1_q.code, s1_q.is_zero, s1_q.is_neg);

  // con_out only moves on a completed evaluation; flush never touches it.
  gp_register #(.WIDTH(1)) u_con_out (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (s1_valid_q),
    .d_i       (con_out_d),
    .q_o       (con_out_o)
  );

  gp_register #(.WIDTH(1)) u_con_valid (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (1'b1),
    .d_i       (s1_valid_q),
    .q_o       (con_valid_o)
  );

`ifdef CON_STATS_EN
  con_sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_stat_taken (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (con_valid_o & con_out_o),
    .clr_i     (stat_clr_i),
    .cnt_o     (stat_taken_o)
  );

  con_sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_stat_not_taken (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (con_valid_o & ~con_out_o),
    .clr_i     (stat_clr_i),
    .cnt_o     (stat_not_taken_o)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_con_eval_unit.sv
// tb_con_eval_unit: extended and legacy instances driven together, checked against a signed-arithmetic model.
`default_nettype none

module tb_con_eval_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        con_in;
  logic        flush;
  logic        stat_clr;
  logic [31:0] ir;
  logic [31:0] bus_data;
  logic        out_e, val_e, out_l, val_l;
`ifdef CON_STATS_EN
  logic [1:0]  st_e, snt_e, st_l, snt_l;
`endif

  always #5 clk = ~clk;

  con_eval_unit #(.EXT_COND(1), .STAT_WIDTH(2)) u_dut_ext (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .con_in_i         (con_in),
    .flush_i          (flush),
    .ir_i             (ir),
    .bus_data_i       (bus_data),
    .con_out_o        (out_e),
    .con_valid_o      (val_e)
`ifdef CON_STATS_EN
    ,
    .stat_clr_i       (stat_clr),
    .stat_taken_o     (st_e),
    .stat_not_taken_o (snt_e)
`endif
  );

  con_eval_unit #(.EXT_COND(0), .STAT_WIDTH(2)) u_dut_leg (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .con_in_i         (con_in),
    .flush_i          (flush),
    .ir_i             (ir),
    .bus_data_i       (bus_data),
    .con_out_o        (out_l),
    .con_valid_o      (val_l)
`ifdef CON_STATS_EN
    ,
    .stat_clr_i       (stat_clr),
    .stat_taken_o     (st_l),
    .stat_not_taken_o (snt_l)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: one pending evaluation, visible outputs, counters [taken_e, nt_e, taken_l, nt_l].
  bit pend;
  bit pres_e, pres_l;
  bit exp_val;
  bit exp_out_e, exp_out_l;
  int cnt [4];

  function automatic bit cond_true(input int code, input logic [31:0] d);
    int v;
    v = $signed(d);
    case (code)
      0:       return v == 0;
      1:       return v != 0;
      2:       return v >= 0;
      3:       return v < 0;
      4:       return v > 0;
      5:       return v <= 0;
      6:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk_ir(input int code);
    logic [31:0] r;
    r = 32'(code & 7) << 19;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sat_inc(input int i);
    if (cnt[i] < 3) cnt[i]++;
  endtask

  task automatic step(input string tag, input bit rn, input bit c, input bit f, input bit sc,
                      input logic [31:0] irv, input logic [31:0] d);
    reset_n  = rn;
    con_in   = c;
    flush    = f;
    stat_clr = sc;
    ir       = irv;
    bus_data = d;
    @(posedge clk);
    if (!rn) begin
      pend = 0; exp_val = 0; exp_out_e = 0; exp_out_l = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end else begin
      if (sc) begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else if (exp_val) begin
        sat_inc(exp_out_e ? 0 : 1);
        sat_inc(exp_out_l ? 2 : 3);
      end
      exp_val = pend;
      if (pend) begin
        exp_out_e = pres_e;
        exp_out_l = pres_l;
      end
      pend = c && !f;
      if (pend) begin
        pres_e = cond_true(int'(irv[21:19]), d);
        pres_l = cond_true(int'(irv[20:19]), d);
      end
    end
    #1;
    chk({tag, " con_out ext"}, 32'(out_e), 32'(exp_out_e));
    chk({tag, " con_valid ext"}, 32'(val_e), 32'(exp_val));
    chk({tag, " con_out leg"}, 32'(out_l), 32'(exp_out_l));
    chk({tag, " con_valid leg"}, 32'(val_l), 32'(exp_val));
`ifdef CON_STATS_EN
    chk({tag, " taken ext"}, 32'(st_e), 32'(cnt[0]));
    chk({tag, " not_taken ext"}, 32'(snt_e), 32'(cnt[1]));
    chk({tag, " taken leg"}, 32'(st_l), 32'(cnt[2]));
    chk({tag, " not_taken leg"}, 32'(snt_l), 32'(cnt[3]));
`endif
  endtask

  initial begin
    // Reset state
    step("reset0", 0, 0, 0, 0, 32'h0, 32'h0);
    step("reset1", 0, 1, 0, 0, mk_ir(6), 32'h1);

    // Zero test: strobe, pulse, then held
    step("eqz_load", 1, 1, 0, 0, mk_ir(0), 32'h0);
    step("eqz_pulse", 1, 0, 0, 0, mk_ir(0), 32'h1);
    chk("eqz_pulse literal", 32'(out_e), 32'd1);
    step("eqz_hold", 1, 0, 0, 0, mk_ir(0), 32'h1);
    chk("eqz_hold literal", 32'(val_e), 32'd0);

    // Back-to-back strobes
    step("b2b0", 1, 1, 0, 0, mk_ir(4), 32'h0000_0005);
    step("b2b1", 1, 1, 0, 0, mk_ir(3), 32'hFFFF_FFFF);
    step("b2b2", 1, 1, 0, 0, mk_ir(5), 32'h0000_0000);
    step("b2b3", 1, 1, 0, 0, mk_ir(4), 32'h0000_0000);
    step("b2b4", 1, 0, 0, 0, 32'h0, 32'h0);
    step("b2b5", 1, 0, 0, 0, 32'h0, 32'h0);
    chk("b2b last literal", 32'(out_e), 32'd0);

    // Code 110: always (extended) versus non-negative (legacy) on a negative value
    step("leg_load", 1, 1, 0, 0, mk_ir(6), 32'h8000_0000);
    step("leg_idle", 1, 0, 0, 0, 32'h0, 32'h0);
    step("leg_res", 1, 0, 0, 0, 32'h0, 32'h0);
    chk("leg ext literal", 32'(out_e), 32'd1);
    chk("leg leg literal", 32'(out_l), 32'd0);

    // Flush in the strobe cycle drops it; flush one cycle later does not
    step("flush_same", 1, 1, 1, 0, mk_ir(7), 32'h0);
    step("flush_same_n1", 1, 0, 0, 0, 32'h0, 32'h0);
    step("flush_late_ld", 1, 1, 0, 0, mk_ir(7), 32'h0);
    step("flush_late", 1, 0, 1, 0, 32'h0, 32'h0);
    step("flush_late_n1", 1, 0, 0, 0, 32'h0, 32'h0);

    // Reset while an evaluation is pending
    step("rst_mid_ld", 1, 1, 0, 0, mk_ir(6), 32'h3);
    step("rst_mid", 0, 0, 0, 0, 32'h0, 32'h0);
    step("rst_mid_n1", 1, 0, 0, 0, 32'h0, 32'h0);

    // Saturation (five taken) and clear coinciding with a valid pulse
    for (int i = 0; i < 5; i++) step("sat", 1, 1, 0, 0, mk_ir(6), 32'h0);
    step("sat_drain0", 1, 0, 0, 0, 32'h0, 32'h0);
    step("sat_drain1", 1, 0, 0, 0, 32'h0, 32'h0);
    step("clr_ld", 1, 1, 0, 0, mk_ir(7), 32'h0);
    step("clr_idle", 1, 0, 0, 0, 32'h0, 32'h0);
    step("clr_hit", 1, 0, 0, 1, 32'h0, 32'h0);
    step("clr_after", 1, 0, 0, 0, 32'h0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      int sel;
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 32'h0 : (sel == 1) ? (32'h8000_0000 | $urandom) : $urandom;
      step("rand", $urandom_range(0, 99) >= 3, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, $urandom, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
